// File: rtl/disp_pkg.sv
// Shared types and pixel layout for the display byte path.
// Used by rgb_byte_sequencer and its line counter.
package disp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND_1 = 2'd1,
      SEND_2 = 2'd2,
      SEND_3 = 2'd3
   } state_t;

   localparam int BYTES_PER_PIX = 3;

   localparam int R_LSB = 16;
   localparam int G_LSB = 8;
   localparam int B_LSB = 0;

   function automatic logic [7:0] pix_byte(
      input logic [23:0] pix,
      input int          lsb
   );
      return pix[lsb +: 8];
   endfunction

endpackage

// File: rtl/line_pix_counter.sv
// Pixel-in-line wrap counter with a terminal-count flag.
// Advances on inc, wrapping from PIXELS_PER_LINE-1 back to 0.
module line_pix_counter #(
   parameter int PIXELS_PER_LINE = 640,
   parameter int CNT_W           = $clog2(PIXELS_PER_LINE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count,
   output logic             tc
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PIXELS_PER_LINE - 1);

   assign tc = (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (inc) begin
         count <= tc ? '0 : count + 1'b1;
      end
   end

endmodule

// File: rtl/rgb_byte_sequencer.sv
// Serialises 24-bit pixels into R/G/B bytes through a one-hot 3:1 mux.
// Define RGB_SEQ_BGR_ORDER_EN to send bytes in B, G, R order instead.
module rgb_byte_sequencer
   import disp_pkg::*;
#(
   parameter int PIXELS_PER_LINE = 640,
   parameter int CNT_W           = $clog2(PIXELS_PER_LINE)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             PixValid,
   input  logic [23:0]      PixData,
   output logic             PixReady,
   output logic [7:0]       R,
   output logic [7:0]       G,
   output logic [7:0]       B,
   output logic             SelR,
   output logic             SelG,
   output logic             SelB,
   output logic             ByteValid,
   input  logic             ByteReady,
   output logic             ByteLast,
   output logic [CNT_W-1:0] PixCount
);

   state_t state;
   state_t state_nxt;

   logic accept;
   logic byte_hs;
   logic last_pix;
   logic pix_done;

   assign ByteValid = (state != IDLE);
   assign PixReady  = (state == IDLE) |
                      ((state == SEND_3) & ByteReady);
   assign accept    = PixValid & PixReady;
   assign byte_hs   = ByteValid & ByteReady;
   assign pix_done  = (state == SEND_3) & ByteReady;
   assign ByteLast  = (state == SEND_3) & last_pix;

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Mux inputs only move on an accept, so they stay stable mid-pixel.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         R <= '0;
         G <= '0;
         B <= '0;
      end else if (accept) begin
         R <= pix_byte(PixData, R_LSB);
         G <= pix_byte(PixData, G_LSB);
         B <= pix_byte(PixData, B_LSB);
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:   if (accept)  state_nxt = SEND_1;
         SEND_1: if (byte_hs) state_nxt = SEND_2;
         SEND_2: if (byte_hs) state_nxt = SEND_3;
         SEND_3: begin
            if (byte_hs) state_nxt = accept ? SEND_1 : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      SelR = 1'b0;
      SelG = 1'b0;
      SelB = 1'b0;
      unique case (state)
         IDLE:   ;
`ifdef RGB_SEQ_BGR_ORDER_EN
         SEND_1: SelB = 1'b1;
         SEND_2: SelG = 1'b1;
         SEND_3: SelR = 1'b1;
`else
         SEND_1: SelR = 1'b1;
         SEND_2: SelG = 1'b1;
         SEND_3: SelB = 1'b1;
`endif
         default: ;
      endcase
   end

   line_pix_counter #(
      .PIXELS_PER_LINE (PIXELS_PER_LINE),
      .CNT_W           (CNT_W)
   ) u_line_cnt (
      .clk   (Clk),
      .rst   (Reset),
      .inc   (pix_done),
      .count (PixCount),
      .tc    (last_pix)
   );

endmodule

// File: tb/tb_rgb_byte_sequencer.sv
// Scoreboard bench for rgb_byte_sequencer with a short line (4 pixels).
// Honours RGB_SEQ_BGR_ORDER_EN for the expected byte order.
module tb_rgb_byte_sequencer;

   localparam int PPL = 4;
   localparam int CW  = $clog2(PPL);

   logic          Clk;
   logic          Reset;
   logic          PixValid;
   logic [23:0]   PixData;
   logic          PixReady;
   logic [7:0]    R, G, B;
   logic          SelR, SelG, SelB;
   logic          ByteValid;
   logic          ByteReady;
   logic          ByteLast;
   logic [CW-1:0] PixCount;

   typedef struct {
      logic [7:0] byte_val;
      logic [2:0] sel;
      logic       last;
      int         cnt;
   } exp_t;

   exp_t q[$];
   int   pix_idx;
   int   vectors;
   int   miscompares;
   bit   running;

   rgb_byte_sequencer #(
      .PIXELS_PER_LINE (PPL)
   ) dut (
      .Clk       (Clk),
      .Reset     (Reset),
      .PixValid  (PixValid),
      .PixData   (PixData),
      .PixReady  (PixReady),
      .R         (R),
      .G         (G),
      .B         (B),
      .SelR      (SelR),
      .SelG      (SelG),
      .SelB      (SelB),
      .ByteValid (ByteValid),
      .ByteReady (ByteReady),
      .ByteLast  (ByteLast),
      .PixCount  (PixCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] mux_out();
      if (SelR) return R;
      if (SelG) return G;
      if (SelB) return B;
      return 8'h00;
   endfunction

   // Reference: every accepted pixel yields three bytes in colour order,
   // all tagged with the pixel's position in the line.
   task automatic push_pixel(input logic [23:0] pix);
      exp_t e;
      logic [7:0] rb, gb, bb;
      rb = pix[23:16];
      gb = pix[15:8];
      bb = pix[7:0];
      e.cnt  = pix_idx;
      e.last = 1'b0;
`ifdef RGB_SEQ_BGR_ORDER_EN
      e.byte_val = bb; e.sel = 3'b001; q.push_back(e);
      e.byte_val = gb; e.sel = 3'b010; q.push_back(e);
      e.byte_val = rb; e.sel = 3'b100;
`else
      e.byte_val = rb; e.sel = 3'b100; q.push_back(e);
      e.byte_val = gb; e.sel = 3'b010; q.push_back(e);
      e.byte_val = bb; e.sel = 3'b001;
`endif
      e.last = (pix_idx == PPL - 1);
      q.push_back(e);
      pix_idx = (pix_idx + 1) % PPL;
   endtask

   // Monitor: inputs settle just after posedge, so at negedge we know
   // which handshakes will complete on the next rising edge.
   always @(negedge Clk) begin
      if (running && !Reset) begin
         check("byte_valid", 32'(ByteValid), 32'(q.size() != 0));
         check("pix_ready", 32'(PixReady),
               32'((q.size() == 0) || (q.size() == 1 && ByteReady)));
         if (q.size() != 0) begin
            check("sel", 32'({SelR, SelG, SelB}), 32'(q[0].sel));
            check("byte", 32'(mux_out()), 32'(q[0].byte_val));
            check("byte_last", 32'(ByteLast), 32'(q[0].last));
            check("pix_count", 32'(PixCount), 32'(q[0].cnt));
            if (ByteReady) void'(q.pop_front());
         end else begin
            check("idle_sel", 32'({SelR, SelG, SelB, ByteLast}), 32'd0);
         end
         if (PixValid && PixReady) push_pixel(PixData);
      end
   end

   task automatic cyc(input logic v, input logic [23:0] d,
                      input logic br);
      @(posedge Clk);
      #1;
      PixValid  = v;
      PixData   = d;
      ByteReady = br;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_rgb"}, 32'({R, G, B}), 32'd0);
      check({tag, "_sel"}, 32'({SelR, SelG, SelB}), 32'd0);
      check({tag, "_valid_last"}, 32'({ByteValid, ByteLast}), 32'd0);
      check({tag, "_count"}, 32'(PixCount), 32'd0);
   endtask

   // Asynchronous reset in the middle of a clock high phase.
   task automatic async_reset();
      @(posedge Clk);
      #3;
      Reset    = 1'b1;
      PixValid = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      q.delete();
      pix_idx = 0;
      @(posedge Clk);
      #2;
      Reset = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      cyc(1'b0, 24'h0, 1'b1);
      while (q.size() != 0 && n < 20) begin
         cyc(1'b0, 24'h0, 1'b1);
         n++;
      end
      check("drain_timeout", 32'(q.size()), 32'd0);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      pix_idx     = 0;
      running     = 1'b0;
      Reset       = 1'b1;
      PixValid    = 1'b0;
      PixData     = '0;
      ByteReady   = 1'b0;
      #12;
      check_reset_outputs("por");
      check("por_ready", 32'(PixReady), 32'd1);
      @(posedge Clk);
      #2;
      Reset   = 1'b0;
      running = 1'b1;

      // Single pixel, downstream always ready.
      cyc(1'b1, 24'hA1B2C3, 1'b1);
      cyc(1'b0, 24'h0, 1'b1);
      drain();

      // Back-to-back stream across a line wrap (5 pixels, line of 4).
      for (int i = 0; i < 5; i++) begin
         cyc(1'b1, 24'(32'h100000 * (i + 1) + 32'h0203 * i), 1'b1);
         while (!PixReady) cyc(1'b1, PixData, 1'b1);
      end
      drain();

      // Downstream stall while the green byte is presented.
      cyc(1'b1, 24'h445566, 1'b1);
      cyc(1'b0, 24'hFFFFFF, 1'b1);
      for (int i = 0; i < 5; i++) cyc(1'b1, 24'hDEAD00, 1'b0);
      cyc(1'b0, 24'h0, 1'b1);
      drain();

      // Reset mid-pixel, then a fresh pixel.
      cyc(1'b1, 24'h778899, 1'b1);
      cyc(1'b0, 24'h0, 1'b1);
      async_reset();
      cyc(1'b1, 24'h010203, 1'b1);
      cyc(1'b0, 24'h0, 1'b1);
      drain();

      // Random traffic with occasional resets.
      for (int i = 0; i < 600; i++) begin
         if (i == 200 || i == 450) begin
            async_reset();
         end else begin
            cyc(($urandom % 4) != 0, 24'($urandom),
                ($urandom % 3) != 0);
         end
      end
      drain();

      running = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/rgb_byte_sequencer.md
Name: rgb_byte_sequencer

Overview:
- Controller for the 3:1 colour byte mux in the display path.
- Accepts one 24-bit pixel per valid/ready handshake and latches its R/G/B bytes onto the mux data inputs.
- Steps the one-hot select lines SelR/SelG/SelB, one byte per accepted downstream handshake, and marks the last byte of each display line.
- Sits between the pixel source (frame/line buffer) and the byte-serial panel interface.

Parameters:
PIXELS_PER_LINE, 640, pixels per display line; must be >= 2.
CNT_W, $clog2(PIXELS_PER_LINE), width of the pixel-in-line counter.

Ports:
Clk  input  1  system clock; all state changes on rising edge.
Reset  input  1  asynchronous, active-high reset.
PixValid  input  1  upstream pixel available.
PixData  input  24  pixel: [23:16]=R, [15:8]=G, [7:0]=B.
PixReady  output  1  sequencer accepts PixData this cycle.
R  output  8  latched red byte to mux.
G  output  8  latched green byte to mux.
B  output  8  latched blue byte to mux.
SelR  output  1  mux select, red.
SelG  output  1  mux select, green.
SelB  output  1  mux select, blue.
ByteValid  output  1  mux output byte is valid this cycle.
ByteReady  input  1  downstream consumes byte when ByteValid & ByteReady.
ByteLast  output  1  current byte is the final byte of a line.
PixCount  output  CNT_W  index of pixel currently being sent, 0..PIXELS_PER_LINE-1.

Behaviour:
- Reset (async, any time, including mid-pixel):
  - State=IDLE; R/G/B=0; Sel*=0; ByteValid=0; ByteLast=0; PixCount=0.
  - A partially sent pixel is discarded and is not resent.
- States: IDLE, SEND_1, SEND_2, SEND_3. Default colour order is R, G, B.
- Selects:
  - Exactly one Sel* is high in each SEND_n; all are 0 in IDLE.
  - ByteValid = (State != IDLE).
- PixReady = (State==IDLE) | (State==SEND_3 & ByteReady). Combinational; depends on ByteReady.
- Pixel accept (PixValid & PixReady):
  - Latch R/G/B from PixData and go to SEND_1 next cycle.
  - Accepting in SEND_3 gives back-to-back pixels: 3 cycles per pixel with ByteReady held high, no bubble.
- Byte advance:
  - SEND_1 -> SEND_2 -> SEND_3 only on ByteValid & ByteReady.
  - With ByteReady low, the state, Sel* and R/G/B hold.
- SEND_3 handshake:
  - With no new pixel accepted, go to IDLE.
  - PixCount increments, wrapping from PIXELS_PER_LINE-1 to 0.
- ByteLast = (State==SEND_3) & (PixCount==PIXELS_PER_LINE-1); combinational from registered state.
- Latency: first byte appears the cycle after the pixel is accepted.
- R/G/B change only on a pixel accept, so mux inputs are stable during SEND_n.
- PixData is ignored when PixReady is low.
- PixValid may drop at any time without effect while a pixel is in flight.

Optional Feature:
- Macro RGB_SEQ_BGR_ORDER_EN.
- Defined: byte order is B, G, R. SEND_1 asserts SelB, SEND_3 asserts SelR. ByteLast still marks SEND_3.
- Undefined: order is R, G, B.
- PixData bit mapping is identical in both cases.

Decomposition:
- Shared package disp_pkg:
  - state typedef: IDLE=2'd0, SEND_1=2'd1, SEND_2=2'd2, SEND_3=2'd3.
  - constant BYTES_PER_PIX=3.
  - pixel field offsets R_LSB=16, G_LSB=8, B_LSB=0.
- One natural sub-module: line_pix_counter (wrap counter with terminal-count flag, parameterised by PIXELS_PER_LINE). Everything else stays in the FSM module.

Test Plan:
1. Reset then a single pixel 24'hA1B2C3 with ByteReady=1 -> PixReady=1 in IDLE, then three ByteValid cycles with SelR/SelG/SelB one-hot in order and mux output A1, B2, C3, then IDLE; PixCount 0->1.
2. PixValid held high, ByteReady=1, 4 pixels -> 12 consecutive ByteValid cycles, no gaps, PixReady high exactly in each SEND_3.
3. ByteReady low for 5 cycles during SEND_2 -> SelG, G and ByteValid held; advances to SEND_3 on the first ByteReady=1 cycle.
4. PIXELS_PER_LINE=4, stream 5 pixels -> ByteLast high only on the 12th byte; PixCount wraps 3->0; ByteLast low for pixel 5.
5. Assert Reset asynchronously mid-SEND_2 -> all outputs 0 immediately; after release the next pixel 24'h010203 is sent starting with SelR.
6. With RGB_SEQ_BGR_ORDER_EN, pixel 24'h112233 -> bytes 33, 22, 11 with SelB, SelG, SelR.
